// File: rtl/store_buffer.sv
// Posted store buffer for the MEM stage: queues byte-enabled word stores,
// merges back-to-back stores to the same word, and drains them in FIFO order.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  in_byteen,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic        load_req,
    input  logic [31:0] load_addr,
    input  logic        mem_ready,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byteen,
    output logic        full,
    output logic        empty,
    output logic        load_conflict
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

    typedef struct packed {
        logic [29:0] word;
        logic [31:0] data;
        logic [3:0]  byteen;
    } entry_t;

    entry_t          entries [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [PW-1:0]   last;
    logic [PW:0]     count;

    logic            pop;
    logic            push_req;
    logic            merge;
    logic            alloc;
    entry_t          head_entry;
    entry_t          tail_entry;
    entry_t          merged_entry;
    logic            conflict_hit;

    // The tail entry is the most recently allocated slot, one behind tail.
    assign last       = tail - PW'(1);
    assign head_entry = entries[head];
    assign tail_entry = entries[last];

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign pop      = !empty && mem_ready;
    assign push_req = (in_byteen != 4'b0000) && !full;

    // Merging into a tail that is leaving this cycle would lose the new bytes.
    assign merge = push_req && !empty
                && (tail_entry.word == in_addr[31:2])
                && ((count >= (PW + 1)'(2)) || !pop);
    assign alloc = push_req && !merge;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        merged_entry = tail_entry;
        for (int i = 0; i < 4; i++) begin
            if (in_byteen[i]) begin
                merged_entry.data[8*i +: 8] = in_wdata[8*i +: 8];
            end
        end
        merged_entry.byteen = tail_entry.byteen | in_byteen;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop) begin
                head <= head + PW'(1);
            end
            if (alloc) begin
                tail <= tail + PW'(1);
            end
            case ({alloc, pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: entry storage is not reset; occupancy is tracked by count and pointers alone.
    always_ff @(posedge clk) begin
        if (alloc) begin
            entries[tail] <= '{word: in_addr[31:2], data: in_wdata, byteen: in_byteen};
        end else if (merge) begin
            entries[last] <= merged_entry;
        end
    end

    assign mem_valid  = !empty;
    assign mem_addr   = empty ? 32'h0 : {head_entry.word, 2'b00};
    assign mem_wdata  = empty ? 32'h0 : head_entry.data;
    assign mem_byteen = empty ? 4'h0  : head_entry.byteen;

    // A slot is live when its distance from head is below count.
    always_comb begin
        logic [PW-1:0] offset;
        offset       = '0;
        conflict_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PW'(i) - head;
            if (({1'b0, offset} < count) && (entries[i].word == load_addr[31:2])) begin
                conflict_hit = 1'b1;
            end
        end
    end

    assign load_conflict = load_req && conflict_hit;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus random traffic, all compared
// against a queue-based model of the buffer's contents.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_byteen;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        load_req;
    logic [31:0] load_addr;
    logic        mem_ready;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byteen;
    logic        full;
    logic        empty;
    logic        load_conflict;

    typedef struct {
        logic [29:0] word;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_byteen     (in_byteen),
        .in_addr       (in_addr),
        .in_wdata      (in_wdata),
        .load_req      (load_req),
        .load_addr     (load_addr),
        .mem_ready     (mem_ready),
        .mem_valid     (mem_valid),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_byteen    (mem_byteen),
        .full          (full),
        .empty         (empty),
        .load_conflict (load_conflict)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model, then advance the model past one edge.
    task automatic step();
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic [3:0]  e_be;
        logic        e_lc;
        bit          m_pop;
        bit          m_push;
        bit          m_merge;
        ent_t        t;

        @(negedge clk);
        e_addr = 32'h0;
        e_data = 32'h0;
        e_be   = 4'h0;
        if (q.size() != 0) begin
            e_addr = {q[0].word, 2'b00};
            e_data = q[0].data;
            e_be   = q[0].be;
        end
        e_lc = 1'b0;
        foreach (q[i]) begin
            if (load_req && q[i].word == load_addr[31:2]) e_lc = 1'b1;
        end
        check("mem_valid", 32'(mem_valid), 32'(q.size() != 0));
        check("mem_addr", mem_addr, e_addr);
        check("mem_wdata", mem_wdata, e_data);
        check("mem_byteen", 32'(mem_byteen), 32'(e_be));
        check("full", 32'(full), 32'(q.size() == DEPTH));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("load_conflict", 32'(load_conflict), 32'(e_lc));

        if (reset) begin
            q.delete();
        end else begin
            m_pop   = (q.size() > 0) && mem_ready;
            m_push  = (in_byteen != 4'h0) && (q.size() < DEPTH);
            m_merge = 1'b0;
            if (m_push && q.size() >= 1) begin
                m_merge = (q[q.size()-1].word == in_addr[31:2]) && (q.size() >= 2 || !m_pop);
            end
            if (m_merge) begin
                t = q[q.size()-1];
                for (int b = 0; b < 4; b++) begin
                    if (in_byteen[b]) t.data[8*b +: 8] = in_wdata[8*b +: 8];
                end
                t.be = t.be | in_byteen;
                q[q.size()-1] = t;
            end
            if (m_pop) void'(q.pop_front());
            if (m_push && !m_merge) begin
                t.word = in_addr[31:2];
                t.data = in_wdata;
                t.be   = in_byteen;
                q.push_back(t);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        in_addr   = a;
        in_byteen = be;
        in_wdata  = d;
    endtask

    task automatic idle();
        in_addr   = 32'h0;
        in_byteen = 4'h0;
        in_wdata  = 32'h0;
    endtask

    initial begin
        reset     = 1'b1;
        load_req  = 1'b0;
        load_addr = 32'h0;
        mem_ready = 1'b0;
        idle();
        @(posedge clk);
        #1;

        // Reset held for two cycles.
        step();
        reset = 1'b0;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);

        // Single store.
        mem_ready = 1'b1;
        store(32'h10, 4'b1111, 32'h12345678);
        step();
        idle();
        check("single_valid", 32'(mem_valid), 32'd1);
        check("single_addr", mem_addr, 32'h10);
        check("single_data", mem_wdata, 32'h12345678);
        check("single_be", 32'(mem_byteen), 32'hF);
        step();
        check("single_empty", 32'(empty), 32'd1);

        // Fill, overflow attempt, drain.
        mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            store(32'(k * 4), 4'b1111, 32'hA0000000 + 32'(k));
            step();
        end
        check("fill_full", 32'(full), 32'd1);
        store(32'h10, 4'b1111, 32'hDEADBEEF);
        step();
        idle();
        check("fill_still_full", 32'(full), 32'd1);
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("drain_addr", mem_addr, 32'(k * 4));
            step();
        end
        check("drain_empty", 32'(empty), 32'd1);

        // Merge of two partial stores to the same word.
        mem_ready = 1'b0;
        store(32'h21, 4'b0010, 32'h0000AB00);
        step();
        store(32'h23, 4'b1000, 32'hCD000000);
        step();
        idle();
        check("merge_addr", mem_addr, 32'h20);
        check("merge_be", 32'(mem_byteen), 32'hA);
        check("merge_b3", 32'(mem_wdata[31:24]), 32'hCD);
        check("merge_b1", 32'(mem_wdata[15:8]), 32'hAB);

        // Load conflict against the pending word.
        load_req  = 1'b1;
        load_addr = 32'h22;
        #1 check("lc_hit", 32'(load_conflict), 32'd1);
        load_addr = 32'h24;
        #1 check("lc_miss", 32'(load_conflict), 32'd0);
        load_req  = 1'b0;
        load_addr = 32'h22;
        #1 check("lc_noreq", 32'(load_conflict), 32'd0);
        mem_ready = 1'b1;
        step();
        check("merge_single_entry", 32'(empty), 32'd1);

        // Alternating push and pop across several pointer wraps.
        for (int k = 0; k < 10; k++) begin
            store(32'h100 + 32'(k * 4), 4'b1111, 32'h5000 + 32'(k));
            step();
            idle();
            check("wrap_addr", mem_addr, 32'h100 + 32'(k * 4));
            step();
        end

        // Reset with three entries pending.
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            store(32'h200 + 32'(k * 4), 4'b1111, 32'h7000 + 32'(k));
            step();
        end
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_empty", 32'(empty), 32'd1);
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("midrst_no_valid", 32'(mem_valid), 32'd0);
            step();
        end

        // Random traffic over a small address set to exercise merges and conflicts.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(2) == 0) begin
                in_byteen = 4'h0;
            end else begin
                in_byteen = 4'($urandom);
            end
            in_addr   = 32'($urandom_range(5) * 4) + 32'($urandom_range(3));
            in_wdata  = $urandom;
            mem_ready = 1'($urandom);
            load_req  = 1'($urandom);
            load_addr = 32'($urandom_range(5) * 4) + 32'($urandom_range(3));
            reset     = ($urandom_range(199) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
